serial_reg_bridge: RTL and testbench

//  Parametrised successor to the host serial command engine. Decodes a byte

---
 rtl/serial_reg_bridge_if.sv | 48 ++++
 rtl/serial_reg_bridge.sv | 266 ++++++++++++++++++++++++++
 tb/tb_serial_reg_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_reg_bridge_if.sv
// Bus bundle between serial_reg_bridge and its surroundings: the UART pair,
// the register file and the sample FIFO.
// The master modport is the bridge; the slave modport is the environment.
// SERBRIDGE_CHKSUM_EN adds the err_chksum pulse to the bundle.
interface serial_reg_bridge_if #(
    parameter int REG_BYTES = 2
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic [5:0]             reg_addr;
    logic [8*REG_BYTES-1:0] reg_wdata;
    logic                   reg_we;
    logic                   reg_rd;
    logic [8*REG_BYTES-1:0] reg_rdata;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [7:0]             fifo_data;
    logic                   err_timeout;
    logic                   busy;
`ifdef SERBRIDGE_CHKSUM_EN
    logic                   err_chksum;

    modport master (
        input  rx_data, rx_valid, tx_busy, reg_rdata, fifo_empty, fifo_data,
        output tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_rd,
               fifo_rd_en, err_timeout, busy, err_chksum
    );
    modport slave (
        output rx_data, rx_valid, tx_busy, reg_rdata, fifo_empty, fifo_data,
        input  tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_rd,
               fifo_rd_en, err_timeout, busy, err_chksum
    );
`else
    modport master (
        input  rx_data, rx_valid, tx_busy, reg_rdata, fifo_empty, fifo_data,
        output tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_rd,
               fifo_rd_en, err_timeout, busy
    );
    modport slave (
        output rx_data, rx_valid, tx_busy, reg_rdata, fifo_empty, fifo_data,
        input  tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_rd,
               fifo_rd_en, err_timeout, busy
    );
`endif
endinterface

// File: rtl/serial_reg_bridge.sv
// serial_reg_bridge: turns a UART byte stream into register-bus writes and
// reads of REG_BYTES-wide words, plus length-limited FIFO burst reads.
// Optional feature macro: SERBRIDGE_CHKSUM_EN (XOR check byte on writes,
// trailing XOR byte on reads and bursts, err_chksum pulse on mismatch).
module serial_reg_bridge #(
    parameter int REG_BYTES   = 2,
    parameter int STREAM_ADDR = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_reg_bridge_if.master  bus
);
    localparam int           W            = 8*REG_BYTES;
    localparam logic [1:0]   LAST_BYTE    = 2'(REG_BYTES-1);
    localparam logic [16:0]  TIMEOUT_LAST = 17'(TIMEOUT_CYC-1);
    localparam logic [5:0]   STREAM       = 6'(STREAM_ADDR);

`ifdef SERBRIDGE_CHKSUM_EN
    typedef enum logic [3:0] {
        IDLE, WR_DATA, WR_CHK, WR_COMMIT, RD_REQ, RD_CAP, RD_SEND,
        ST_LEN, ST_FETCH, ST_LOAD, ST_SEND, CK_SEND
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, WR_DATA, WR_COMMIT, RD_REQ, RD_CAP, RD_SEND,
        ST_LEN, ST_FETCH, ST_LOAD, ST_SEND
    } state_t;
`endif

    state_t       r_state, w_stateNxt;
    logic [5:0]   r_addr, w_addrNxt;
    logic [W-1:0] r_word, w_wordNxt;
    logic [1:0]   r_byteCnt, w_byteCntNxt;
    logic [8:0]   r_burstLeft, w_burstNxt;
    logic [16:0]  r_timer, w_timerNxt;
    logic [7:0]   r_txData, w_txDataNxt;
    logic         r_txPrev;
    logic         r_errTo, w_errToNxt;
    logic         w_sendState;
    logic         w_txStart;
    logic         w_timeoutHit;
`ifdef SERBRIDGE_CHKSUM_EN
    logic [7:0]   r_chk, w_chkNxt;
    logic         r_errCk, w_errCkNxt;
`endif

`ifdef SERBRIDGE_CHKSUM_EN
    assign w_sendState = (r_state == RD_SEND) || (r_state == ST_SEND) || (r_state == CK_SEND);
`else
    assign w_sendState = (r_state == RD_SEND) || (r_state == ST_SEND);
`endif

    // A byte goes out only into an idle transmitter and never on two
    // consecutive cycles, which hides the transmitter's busy-rise latency.
    assign w_txStart    = !reset && w_sendState && !bus.tx_busy && !r_txPrev;
    assign w_timeoutHit = (r_timer == TIMEOUT_LAST);

    assign bus.tx_start    = w_txStart;
    assign bus.tx_data     = r_txData;
    assign bus.reg_addr    = r_addr;
    assign bus.reg_wdata   = r_word;
    assign bus.reg_we      = !reset && (r_state == WR_COMMIT);
    assign bus.reg_rd      = !reset && (r_state == RD_REQ);
    assign bus.fifo_rd_en  = !reset && (r_state == ST_FETCH) && !bus.fifo_empty;
    assign bus.err_timeout = r_errTo;
    assign bus.busy        = (r_state != IDLE);
`ifdef SERBRIDGE_CHKSUM_EN
    assign bus.err_chksum  = r_errCk;
`endif

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_word      <= '0;
            r_byteCnt   <= '0;
            r_burstLeft <= '0;
            r_timer     <= '0;
            r_txData    <= '0;
            r_txPrev    <= 1'b0;
            r_errTo     <= 1'b0;
`ifdef SERBRIDGE_CHKSUM_EN
            r_chk       <= '0;
            r_errCk     <= 1'b0;
`endif
        end else begin
            r_state     <= w_stateNxt;
            r_addr      <= w_addrNxt;
            r_word      <= w_wordNxt;
            r_byteCnt   <= w_byteCntNxt;
            r_burstLeft <= w_burstNxt;
            r_timer     <= w_timerNxt;
            r_txData    <= w_txDataNxt;
            r_txPrev    <= w_txStart;
            r_errTo     <= w_errToNxt;
`ifdef SERBRIDGE_CHKSUM_EN
            r_chk       <= w_chkNxt;
            r_errCk     <= w_errCkNxt;
`endif
        end
    end

    // Frame decoder: next state and next datapath values for every state.
    always_comb begin
        w_stateNxt   = r_state;
        w_addrNxt    = r_addr;
        w_wordNxt    = r_word;
        w_byteCntNxt = r_byteCnt;
        w_burstNxt   = r_burstLeft;
        w_timerNxt   = r_timer;
        w_txDataNxt  = r_txData;
        w_errToNxt   = 1'b0;
`ifdef SERBRIDGE_CHKSUM_EN
        w_chkNxt     = r_chk;
        w_errCkNxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_timerNxt = '0;
                if (bus.rx_valid && bus.rx_data[7]) begin
                    w_addrNxt    = bus.rx_data[5:0];
                    w_byteCntNxt = '0;
                    w_wordNxt    = '0;
`ifdef SERBRIDGE_CHKSUM_EN
                    w_chkNxt     = bus.rx_data;
`endif
                    if (bus.rx_data[6])
                        w_stateNxt = WR_DATA;
                    else if (bus.rx_data[5:0] == STREAM)
                        w_stateNxt = ST_LEN;
                    else
                        w_stateNxt = RD_REQ;
                end
            end
            WR_DATA: begin
                if (bus.rx_valid) begin
                    w_timerNxt = '0;
                    for (int i = 0; i < REG_BYTES; i++)
                        if (int'(r_byteCnt) == i)
                            w_wordNxt[8*i +: 8] = bus.rx_data;
`ifdef SERBRIDGE_CHKSUM_EN
                    w_chkNxt = r_chk ^ bus.rx_data;
`endif
                    if (r_byteCnt == LAST_BYTE) begin
`ifdef SERBRIDGE_CHKSUM_EN
                        w_stateNxt = WR_CHK;
`else
                        w_stateNxt = WR_COMMIT;
`endif
                    end else begin
                        w_byteCntNxt = r_byteCnt + 2'd1;
                    end
                end else if (w_timeoutHit) begin
                    w_errToNxt = 1'b1;
                    w_stateNxt = IDLE;
                end else begin
                    w_timerNxt = r_timer + 17'd1;
                end
            end
`ifdef SERBRIDGE_CHKSUM_EN
            WR_CHK: begin
                if (bus.rx_valid) begin
                    w_timerNxt = '0;
                    if (bus.rx_data == r_chk) begin
                        w_stateNxt = WR_COMMIT;
                    end else begin
                        w_errCkNxt = 1'b1;
                        w_stateNxt = IDLE;
                    end
                end else if (w_timeoutHit) begin
                    w_errToNxt = 1'b1;
                    w_stateNxt = IDLE;
                end else begin
                    w_timerNxt = r_timer + 17'd1;
                end
            end
            CK_SEND: begin
                if (w_txStart)
                    w_stateNxt = IDLE;
            end
`endif
            WR_COMMIT: w_stateNxt = IDLE;
            RD_REQ:    w_stateNxt = RD_CAP;
            RD_CAP: begin
                w_txDataNxt  = bus.reg_rdata[7:0];
                w_wordNxt    = bus.reg_rdata >> 8;
                w_byteCntNxt = '0;
`ifdef SERBRIDGE_CHKSUM_EN
                w_chkNxt     = '0;
`endif
                w_stateNxt   = RD_SEND;
            end
            RD_SEND: begin
                if (w_txStart) begin
`ifdef SERBRIDGE_CHKSUM_EN
                    w_chkNxt = r_chk ^ r_txData;
`endif
                    if (r_byteCnt == LAST_BYTE) begin
`ifdef SERBRIDGE_CHKSUM_EN
                        w_txDataNxt = r_chk ^ r_txData;
                        w_stateNxt  = CK_SEND;
`else
                        w_stateNxt  = IDLE;
`endif
                    end else begin
                        w_txDataNxt  = r_word[7:0];
                        w_wordNxt    = r_word >> 8;
                        w_byteCntNxt = r_byteCnt + 2'd1;
                    end
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    w_timerNxt = '0;
                    w_burstNxt = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
`ifdef SERBRIDGE_CHKSUM_EN
                    w_chkNxt   = '0;
`endif
                    w_stateNxt = ST_FETCH;
                end else if (w_timeoutHit) begin
                    w_errToNxt = 1'b1;
                    w_stateNxt = IDLE;
                end else begin
                    w_timerNxt = r_timer + 17'd1;
                end
            end
            ST_FETCH: begin
                if (bus.fifo_empty) begin
`ifdef SERBRIDGE_CHKSUM_EN
                    w_txDataNxt = r_chk;
                    w_stateNxt  = CK_SEND;
`else
                    w_stateNxt  = IDLE;
`endif
                end else begin
                    w_stateNxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_txDataNxt = bus.fifo_data;
                w_stateNxt  = ST_SEND;
            end
            ST_SEND: begin
                if (w_txStart) begin
`ifdef SERBRIDGE_CHKSUM_EN
                    w_chkNxt = r_chk ^ r_txData;
`endif
                    if (r_burstLeft == 9'd1) begin
`ifdef SERBRIDGE_CHKSUM_EN
                        w_txDataNxt = r_chk ^ r_txData;
                        w_stateNxt  = CK_SEND;
`else
                        w_stateNxt  = IDLE;
`endif
                    end else begin
                        w_burstNxt = r_burstLeft - 9'd1;
                        w_stateNxt = ST_FETCH;
                    end
                end
            end
            default: w_stateNxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_reg_bridge.sv
// Testbench for serial_reg_bridge: table of whole frames with hand-computed
// results, plus hand-written timeout, busy-hold, mid-frame reset sequences.
// Honours SERBRIDGE_CHKSUM_EN for the expected byte streams.
module tb_serial_reg_bridge;
    localparam int RB = 2;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_reg_bridge_if #(.REG_BYTES(RB)) bus();

    serial_reg_bridge #(.REG_BYTES(RB), .STREAM_ADDR(3), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Transmitter model: busy for four cycles after each start, plus override.
    int   busyCnt = 0;
    logic holdBusy = 1'b0;
    always @(posedge clk) begin
        if (reset) busyCnt <= 0;
        else if (bus.tx_start) busyCnt <= 4;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end
    assign bus.tx_busy = (busyCnt != 0) || holdBusy;

    // Sample FIFO model: data appears the cycle after a pop.
    logic [7:0] fifoMem [64];
    int   wrPtr = 0;
    int   rdPtr = 0;
    logic flushReq = 1'b0;
    always @(posedge clk) begin
        if (flushReq) rdPtr <= wrPtr;
        else if (bus.fifo_rd_en && rdPtr != wrPtr) begin
            bus.fifo_data <= fifoMem[rdPtr % 64];
            rdPtr <= rdPtr + 1;
        end
    end
    assign bus.fifo_empty = (rdPtr == wrPtr);

    // Bus monitor: counts strobes and logs transmitted bytes.
    int weCount = 0, rdCount = 0, popCount = 0, txCount = 0, toCount = 0, ckCount = 0, txViol = 0;
    logic [5:0]  lastAddr = '0;
    logic [15:0] lastWdata = '0;
    logic [7:0]  txLog [1024];
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.reg_we) begin
                weCount   <= weCount + 1;
                lastAddr  <= bus.reg_addr;
                lastWdata <= bus.reg_wdata;
            end
            if (bus.reg_rd) rdCount <= rdCount + 1;
            if (bus.fifo_rd_en) popCount <= popCount + 1;
            if (bus.err_timeout) toCount <= toCount + 1;
`ifdef SERBRIDGE_CHKSUM_EN
            if (bus.err_chksum) ckCount <= ckCount + 1;
`endif
            if (bus.tx_start) begin
                txLog[txCount % 1024] <= bus.tx_data;
                txCount <= txCount + 1;
                if (bus.tx_busy) txViol <= txViol + 1;
            end
        end
    end

    typedef struct {
        int          nRx;
        logic [31:0] rx;
        logic [15:0] rdata;
        int          nFifo;
        logic [47:0] fifo;
        int          expWe;
        logic [5:0]  expAddr;
        logic [15:0] expWdata;
        int          expRd;
        int          expTx;
        logic [47:0] expTxBytes;
        int          expPops;
        int          expLeft;
    } vec_t;

    vec_t vecs [8];
    int we0, rd0, pop0, tx0, to0, ck0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic snap();
        we0 = weCount; rd0 = rdCount; pop0 = popCount;
        tx0 = txCount; to0 = toCount; ck0 = ckCount;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle"}, int'(n < 3000), 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk); flushReq = 1'b1;
        @(negedge clk); flushReq = 1'b0;
        for (int i = 0; i < v.nFifo; i++) begin
            fifoMem[wrPtr % 64] = v.fifo[8*i +: 8];
            wrPtr++;
        end
        bus.reg_rdata = v.rdata;
        snap();
        for (int i = 0; i < v.nRx; i++) sendByte(v.rx[8*i +: 8]);
        waitIdle(name);
    endtask

    task automatic checkVector(input vec_t v, input string name);
        checkOutput({name, "_we"}, weCount - we0, v.expWe);
        if (v.expWe != 0) begin
            checkOutput({name, "_wdata"}, int'(lastWdata), int'(v.expWdata));
            checkOutput({name, "_weAddr"}, int'(lastAddr), int'(v.expAddr));
        end
        checkOutput({name, "_addr"}, int'(bus.reg_addr), int'(v.expAddr));
        checkOutput({name, "_rd"}, rdCount - rd0, v.expRd);
        checkOutput({name, "_txCount"}, txCount - tx0, v.expTx);
        for (int i = 0; i < v.expTx && i < 6; i++)
            checkOutput($sformatf("%s_tx%0d", name, i), int'(txLog[(tx0 + i) % 1024]),
                        int'(v.expTxBytes[8*i +: 8]));
        checkOutput({name, "_pops"}, popCount - pop0, v.expPops);
        checkOutput({name, "_fifoLeft"}, wrPtr - rdPtr, v.expLeft);
        checkOutput({name, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t t;
        int   n;
        // Frame table: rx bytes and FIFO/tx bytes are listed first-byte-in-LSB.
`ifdef SERBRIDGE_CHKSUM_EN
        vecs[0] = '{4, 32'hE3_12_34_C5, 16'h0000, 0, 48'h0, 1, 6'h05, 16'h1234, 0, 0, 48'h0, 0, 0};
        vecs[1] = '{1, 32'h85, 16'hBEEF, 0, 48'h0, 0, 6'h05, 16'h0, 1, 3, 48'h51_BE_EF, 0, 0};
        vecs[2] = '{2, 32'h04_83, 16'h0, 5, 48'h55_44_33_22_11, 0, 6'h03, 16'h0, 0, 5, 48'h44_44_33_22_11, 4, 1};
        vecs[3] = '{2, 32'h00_83, 16'h0, 3, 48'hCC_BB_AA, 0, 6'h03, 16'h0, 0, 4, 48'hDD_CC_BB_AA, 3, 0};
        vecs[4] = '{1, 32'h45, 16'h0, 0, 48'h0, 0, 6'h03, 16'h0, 0, 0, 48'h0, 0, 0};
        vecs[5] = '{4, 32'hA5_AB_CD_C3, 16'h0, 0, 48'h0, 1, 6'h03, 16'hABCD, 0, 0, 48'h0, 0, 0};
        vecs[6] = '{1, 32'h80, 16'h0001, 0, 48'h0, 0, 6'h00, 16'h0, 1, 3, 48'h01_00_01, 0, 0};
        vecs[7] = '{2, 32'h02_83, 16'h0, 0, 48'h0, 0, 6'h03, 16'h0, 0, 1, 48'h00, 0, 0};
`else
        vecs[0] = '{3, 32'h12_34_C5, 16'h0000, 0, 48'h0, 1, 6'h05, 16'h1234, 0, 0, 48'h0, 0, 0};
        vecs[1] = '{1, 32'h85, 16'hBEEF, 0, 48'h0, 0, 6'h05, 16'h0, 1, 2, 48'hBE_EF, 0, 0};
        vecs[2] = '{2, 32'h04_83, 16'h0, 5, 48'h55_44_33_22_11, 0, 6'h03, 16'h0, 0, 4, 48'h44_33_22_11, 4, 1};
        vecs[3] = '{2, 32'h00_83, 16'h0, 3, 48'hCC_BB_AA, 0, 6'h03, 16'h0, 0, 3, 48'hCC_BB_AA, 3, 0};
        vecs[4] = '{1, 32'h45, 16'h0, 0, 48'h0, 0, 6'h03, 16'h0, 0, 0, 48'h0, 0, 0};
        vecs[5] = '{3, 32'hAB_CD_C3, 16'h0, 0, 48'h0, 1, 6'h03, 16'hABCD, 0, 0, 48'h0, 0, 0};
        vecs[6] = '{1, 32'h80, 16'h0001, 0, 48'h0, 0, 6'h00, 16'h0, 1, 2, 48'h00_01, 0, 0};
        vecs[7] = '{2, 32'h02_83, 16'h0, 0, 48'h0, 0, 6'h03, 16'h0, 0, 0, 48'h0, 0, 0};
`endif

        reset         = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.reg_rdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",   int'(bus.busy), 0);
        checkOutput("rst_we",     int'(bus.reg_we), 0);
        checkOutput("rst_rd",     int'(bus.reg_rd), 0);
        checkOutput("rst_txStart",int'(bus.tx_start), 0);
        checkOutput("rst_fifoRd", int'(bus.fifo_rd_en), 0);
        checkOutput("rst_errTo",  int'(bus.err_timeout), 0);
        checkOutput("rst_addr",   int'(bus.reg_addr), 0);
        checkOutput("rst_txData", int'(bus.tx_data), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] frame table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
            checkVector(vecs[i], $sformatf("v%0d", i));
        end

        $display("[TB] timeout sequence");
        snap();
        sendByte(8'hC1);
        sendByte(8'hAA);
        n = 0;
        while (toCount == to0 && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_latency", int'(n >= TO - 10 && n <= TO + 5), 1);
        repeat (4) @(negedge clk);
        checkOutput("to_pulses", toCount - to0, 1);
        checkOutput("to_we", weCount - we0, 0);
        checkOutput("to_busy", int'(bus.busy), 0);
`ifdef SERBRIDGE_CHKSUM_EN
        t = '{1, 32'h81, 16'h2211, 0, 48'h0, 0, 6'h01, 16'h0, 1, 3, 48'h33_22_11, 0, 0};
`else
        t = '{1, 32'h81, 16'h2211, 0, 48'h0, 0, 6'h01, 16'h0, 1, 2, 48'h22_11, 0, 0};
`endif
        applyStimulus(t, "after_to");
        checkVector(t, "after_to");

        $display("[TB] transmitter held busy");
        bus.reg_rdata = 16'h1357;
        holdBusy = 1'b1;
        snap();
        sendByte(8'h85);
        repeat (20) @(negedge clk);
        sendByte(8'hC5);
        repeat (76) @(negedge clk);
        checkOutput("hold_noTx", txCount - tx0, 0);
        holdBusy = 1'b0;
        waitIdle("hold");
`ifdef SERBRIDGE_CHKSUM_EN
        t = '{1, 32'h85, 16'h1357, 0, 48'h0, 0, 6'h05, 16'h0, 1, 3, 48'h44_13_57, 0, 0};
`else
        t = '{1, 32'h85, 16'h1357, 0, 48'h0, 0, 6'h05, 16'h0, 1, 2, 48'h13_57, 0, 0};
`endif
        checkVector(t, "hold");

        $display("[TB] reset mid-frame");
        snap();
        sendByte(8'hC5);
        sendByte(8'h34);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sendByte(8'h12);
        waitIdle("midrst");
        checkOutput("midrst_we", weCount - we0, 0);
        checkOutput("midrst_tx", txCount - tx0, 0);

`ifdef SERBRIDGE_CHKSUM_EN
        $display("[TB] checksum mismatch");
        snap();
        sendByte(8'hC5);
        sendByte(8'h34);
        sendByte(8'h12);
        sendByte(8'h00);
        waitIdle("ckbad");
        checkOutput("ckbad_err", ckCount - ck0, 1);
        checkOutput("ckbad_we", weCount - we0, 0);
        checkOutput("ckbad_to", toCount - to0, 0);
`endif

        checkOutput("tx_whileBusy", txViol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
